bitexpand: RTL and testbench

Streaming bit-width expander that widens narrow signed samples (IWID bits) to a wider signed word (OWID bits). It selects, per sample, how the new low-order bits are filled: zero, half-LSB midpoint, or LFSR dither. It is the reconstruction counterpart to the team's rounding/requantisation stage, and sits between a narrow datapath and a wider filter or interpolator input. Valid/ready handshaking on both sides through a two-entry skid stage allows full throughput under backpressure.

---
 rtl/bitexpand.sv | 92 +++++++++
 tb/tb_bitexpand.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bitexpand.sv
// Streaming signed width expander: widens IWID-bit samples to OWID bits with
// zero, half-LSB midpoint or LFSR-dither fill, behind a two-entry skid stage.
module bitexpand #(
  parameter int IWID = 5,
  parameter int OWID = 8
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [IWID-1:0] i_data,
  input  logic [1:0]      i_mode,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [OWID-1:0] o_data
);
  localparam int K = OWID - IWID;

  // Handshake: a sample moves on any rising edge where its valid and ready are
  // both high; valid never depends on ready, and o_ready is a registered flag.
  logic            skid_valid;
  logic [OWID-1:0] skid_data;
  logic [15:0]     lfsr;

  logic            in_xfer;
  logic            out_xfer;
  logic            fb;
  logic [K-1:0]    fill;
  logic [OWID-1:0] wide;

  logic            o_valid_n;
  logic [OWID-1:0] o_data_n;
  logic            skid_valid_n;
  logic [OWID-1:0] skid_data_n;
  logic [15:0]     lfsr_n;

  assign in_xfer  = i_valid && o_ready;
  assign out_xfer = o_valid && i_ready;
  assign fb       = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_comb begin
    fill = '0;
    case (i_mode)
      2'd1:    fill[K-1] = 1'b1;
      2'd2:    fill = lfsr[K-1:0];
      default: fill = '0;
    endcase
  end

  // No sign extension: the narrow sample keeps the top bits of the word.
  assign wide = {i_data, fill};

  always_comb begin
    o_valid_n    = o_valid;
    o_data_n     = o_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    lfsr_n       = lfsr;
    if (in_xfer) lfsr_n = {lfsr[14:0], fb};
    // in_xfer cannot coincide with a full skid because o_ready is !skid_valid.
    if (out_xfer && skid_valid) begin
      o_data_n     = skid_data;
      skid_valid_n = 1'b0;
    end else if (in_xfer && (!o_valid || i_ready)) begin
      o_data_n  = wide;
      o_valid_n = 1'b1;
    end else if (in_xfer) begin
      skid_data_n  = wide;
      skid_valid_n = 1'b1;
    end else if (out_xfer) begin
      o_valid_n = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      o_ready    <= 1'b1;
      lfsr       <= 16'hACE1;
    end else begin
      o_valid    <= o_valid_n;
      o_data     <= o_data_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      o_ready    <= !skid_valid_n;
      lfsr       <= lfsr_n;
    end
  end
endmodule

// File: tb/tb_bitexpand.sv
// Directed bench for bitexpand: driver pushes hand-computed words into an
// expected queue, a negedge monitor pops and compares on each output transfer.
module tb_bitexpand;
  localparam int IWID = 5;
  localparam int OWID = 8;

  logic            i_clk;
  logic            i_reset_n;
  logic            i_valid;
  logic            o_ready;
  logic [IWID-1:0] i_data;
  logic [1:0]      i_mode;
  logic            o_valid;
  logic            i_ready;
  logic [OWID-1:0] o_data;

  logic [OWID-1:0] exp_q[$];
  logic [15:0]     tb_lfsr;
  int              checks;
  int              errors;

  bitexpand #(.IWID(IWID), .OWID(OWID)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_mode(i_mode), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data)
  );

  // clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // driver: called at posedge+1, returns at posedge+1 after the accepting edge
  task automatic send(input logic [IWID-1:0] d, input logic [1:0] m, input logic [OWID-1:0] exp);
    bit done;
    done = 1'b0;
    i_valid = 1'b1;
    i_data  = d;
    i_mode  = m;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge i_clk);
      if (o_ready) begin
        exp_q.push_back(exp);
        tb_lfsr = lfsr_step(tb_lfsr);
        done = 1'b1;
      end
      @(posedge i_clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: o_ready stayed 0, required 1 within 20 cycles");
    end
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_data  = '0;
    i_mode  = 2'd0;
  endtask

  // scoreboard monitor
  always @(negedge i_clk) begin
    if (i_reset_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h with empty expected queue", o_data);
      end else begin
        check("o_data", o_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    tb_lfsr = 16'hACE1;
    i_reset_n = 1'b0;
    i_ready = 1'b1;
    idle();
    #13;
    check("reset_o_valid", o_valid, 1'b0);
    check("reset_o_data", o_data, 8'h00);
    check("reset_o_ready", o_ready, 1'b1);
    #10 i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;

    // dither: first three transfers after reset
    send(5'd0, 2'd2, 8'h01);
    send(5'd0, 2'd2, 8'h03);
    send(5'd0, 2'd2, 8'h07);
    // zero and midpoint fill
    send(5'b10110, 2'd0, 8'hB0);
    send(5'b01011, 2'd1, 8'h5C);
    send(5'b11111, 2'd1, 8'hFC);
    send(5'b00101, 2'd3, 8'h28);
    // LFSR kept advancing through the non-dither samples
    send(5'b10000, 2'd2, {5'b10000, tb_lfsr[2:0]});
    idle();
    repeat (3) @(posedge i_clk);
    #1;

    // backpressure
    i_ready = 1'b0;
    send(5'b00001, 2'd0, 8'h08);
    send(5'b00010, 2'd0, 8'h10);
    fork
      send(5'b00011, 2'd0, 8'h18);
      begin
        repeat (3) @(posedge i_clk);
        #1;
        check("bp_o_ready", o_ready, 1'b0);
        check("bp_o_valid", o_valid, 1'b1);
        check("bp_hold_data", o_data, 8'h08);
        i_ready = 1'b1;
      end
    join
    idle();
    repeat (3) @(posedge i_clk);
    #1;

    // streaming
    for (int i = 0; i < 16; i++) begin
      logic [IWID-1:0] d;
      d = IWID'(i * 3 + 1);
      send(d, 2'd0, {d, 3'b000});
      check("stream_o_valid", o_valid, 1'b1);
      check("stream_o_ready", o_ready, 1'b1);
    end
    idle();
    repeat (3) @(posedge i_clk);
    #1;

    // reset mid-stream with output and skid occupied
    i_ready = 1'b0;
    send(5'b01010, 2'd0, 8'h50);
    send(5'b01100, 2'd0, 8'h60);
    idle();
    check("pre_reset_o_ready", o_ready, 1'b0);
    #2 i_reset_n = 1'b0;
    #1;
    check("mid_reset_o_valid", o_valid, 1'b0);
    check("mid_reset_o_data", o_data, 8'h00);
    check("mid_reset_o_ready", o_ready, 1'b1);
    exp_q.delete();
    tb_lfsr = 16'hACE1;
    #2 i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    send(5'd0, 2'd2, 8'h01);
    idle();

    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge i_clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
